// File: rtl/ins_pkg.sv
// Shared opcode, condition-code and sequencer state definitions for s_proc_v1.
// Used by ins_seq and by the instruction decoder.
package ins_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_INP   = 4'b1010;
    localparam logic [3:0] OP_OUTP  = 4'b1110;
    localparam logic [3:0] OP_JUMP  = 4'b1000;
    localparam logic [3:0] OP_JCOND = 4'b1001;

    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_NZ = 2'b01;
    localparam logic [1:0] CC_C  = 2'b10;
    localparam logic [1:0] CC_NC = 2'b11;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_ARG,
        DECODE,
        EXECUTE
    } state_t;

    function automatic logic is_io_op(input logic [7:0] op);
        return (op[7:4] == OP_INP) || (op[7:4] == OP_OUTP);
    endfunction

endpackage

// File: rtl/ins_seq_br_cond.sv
// Branch condition evaluation: take=1 for jump, or conditional jump whose
// Z/NZ/C/NC condition holds.
module br_cond
    import ins_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       take
);

    logic unused_ir_lsb;
    assign unused_ir_lsb = ^ir[1:0];

    always_comb begin
        take = 1'b0;
        case (ir[7:4])
            OP_JUMP:  take = 1'b1;
            OP_JCOND: begin
                case (ir[3:2])
                    CC_Z:    take = zero_flag;
                    CC_NZ:   take = ~zero_flag;
                    CC_C:    take = carry_flag;
                    CC_NC:   take = ~carry_flag;
                    default: take = 1'b0;
                endcase
            end
            default:  take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ins_seq.sv
// Instruction sequencer: two-byte fetch over req/ack, decode/execute strobes, PC
// with jump redirection. Define INS_SEQ_IO_WAIT_EN to hold EXECUTE on inp/outp until io_ack.
module ins_seq
    import ins_pkg::*;
#(
    parameter int unsigned PC_W = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            io_ack,
    output logic [7:0]      ir,
    output logic [7:0]      operand,
    output logic [PC_W-1:0] pc,
    output logic            decode,
    output logic            execute
);

    state_t          state;
    logic            take;
    logic            exec_done;
    logic [PC_W-1:0] target;

    br_cond u_br_cond (
        .ir         (ir),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .take       (take)
    );

    generate
        if (PC_W > 8) begin : g_tgt_wide
            assign target = {{(PC_W-8){1'b0}}, operand};
        end else begin : g_tgt_narrow
            assign target = operand[PC_W-1:0];
        end
    endgenerate

`ifdef INS_SEQ_IO_WAIT_EN
    assign exec_done = ~is_io_op(ir) | io_ack;
`else
    logic unused_io_ack;
    assign unused_io_ack = io_ack;
    assign exec_done     = 1'b1;
`endif

    // Request is gated by rst_n so it is low while reset is held, yet rises in
    // the very first cycle reset is released.
    assign mem_req  = rst_n && ((state == FETCH_OP) || (state == FETCH_ARG));
    assign mem_addr = pc;
    assign decode   = (state == DECODE);
    assign execute  = (state == EXECUTE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH_OP;
            pc      <= '0;
            ir      <= '0;
            operand <= '0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + PC_W'(1);
                        state <= FETCH_ARG;
                    end
                end
                FETCH_ARG: begin
                    if (mem_ack) begin
                        operand <= mem_rdata;
                        pc      <= pc + PC_W'(1);
                        state   <= DECODE;
                    end
                end
                DECODE: state <= EXECUTE;
                EXECUTE: begin
                    if (exec_done) begin
                        if (take) pc <= target;
                        state <= FETCH_OP;
                    end
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

endmodule

// File: doc/ins_seq.md
# ins_seq

Instruction sequencer for the s_proc_v1 core. It fetches each two-byte instruction (opcode byte, then operand byte) from program memory over a req/ack handshake, and presents `ir` and `operand` to the instruction decoder. It drives that decoder's one-cycle `decode` and `execute` phase strobes and maintains the program counter, including jump and conditional-jump redirection.

## Interface
Parameters:
- `PC_W`, 8, program counter / memory address width.

Ports:
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mem_req`  out  1  fetch request, held until acknowledged.
- `mem_addr`  out  PC_W  fetch address; equals `pc` while `mem_req` is high.
- `mem_ack`  in  1  fetch accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8  fetched byte.
- `zero_flag`  in  1  datapath Z flag, sampled in EXECUTE.
- `carry_flag`  in  1  datapath C flag, sampled in EXECUTE.
- `io_ack`  in  1  I/O transfer complete; used only when `INS_SEQ_IO_WAIT_EN` is defined.
- `ir`  out  8  instruction register, feeds the decoder.
- `operand`  out  8  operand register (address or immediate).
- `pc`  out  PC_W  program counter.
- `decode`  out  1  decode-phase strobe.
- `execute`  out  1  execute-phase strobe.

## Operation
- Opcode map, taken from `ir[7:4]`:
  - load 0000, and 0001, add 0100, sub 0110, inp 1010, outp 1110, jump 1000.
  - Conditional jump 1001, with the condition in `ir[3:2]`: 00 = Z, 01 = NZ, 10 = C, 11 = NC.
  - Any other opcode is a NOP: it passes through all phases with no effect.
- States: FETCH_OP → FETCH_ARG → DECODE → EXECUTE → FETCH_OP.
- FETCH_OP:
  - Assert `mem_req` with `mem_addr`=`pc`.
  - On `mem_ack`: `ir`←`mem_rdata`, `pc`←`pc`+1, go to FETCH_ARG.
- FETCH_ARG:
  - Same handshake as FETCH_OP.
  - On `mem_ack`: `operand`←`mem_rdata`, `pc`←`pc`+1, go to DECODE.
- DECODE: `decode`=1 for exactly one cycle, then go to EXECUTE.
- EXECUTE: `execute`=1.
  - On jump, or on a conditional jump whose condition is true: `pc`←`operand[PC_W-1:0]`, zero-extended when PC_W>8.
  - Flags are sampled in this cycle. A false condition leaves `pc` unchanged.
- PC arithmetic is modulo 2^PC_W: increment from all-ones wraps to 0. An operand fetch at wrap reads address 0.
- `mem_req` stays high while waiting. `mem_addr` must not change until `mem_ack` arrives.
- `mem_ack` is ignored when `mem_req` is low.
- `decode` and `execute` are mutually exclusive and are never high together with `mem_req`.
- Reset:
  - `rst_n`=0 at any edge, including mid-fetch or mid-execute, gives `pc`=0, `ir`=0, `operand`=0, state FETCH_OP, and all outputs low.
  - The outstanding fetch is abandoned. A late `mem_ack` during reset is ignored.

## Timing
- Reset values: `mem_req` 0, `mem_addr` 0, `ir` 0, `operand` 0, `pc` 0, `decode` 0, `execute` 0.
- First `mem_req` is in the first cycle with `rst_n`=1.
- Zero-wait memory (`mem_ack` in the request cycle): one instruction every 4 cycles (FETCH_OP, FETCH_ARG, DECODE, EXECUTE).
- Each memory wait cycle adds one cycle.
- `ir` and `operand` are stable from DECODE through EXECUTE.
- A redirected `pc` is visible in the cycle after EXECUTE, and is the address of the next FETCH_OP.

## Configuration
- `INS_SEQ_IO_WAIT_EN` defined:
  - For inp (1010) or outp (1110), EXECUTE holds with `execute`=1 until a cycle with `io_ack`=1, then exits.
  - Other opcodes ignore `io_ack`.
- Not defined: EXECUTE is always exactly one cycle and `io_ack` is unused.

## Structure
- Shared package `ins_pkg`: opcode constants (OP_LOAD, OP_AND, OP_ADD, OP_SUB, OP_INP, OP_OUTP, OP_JUMP, OP_JCOND), condition codes (CC_Z, CC_NZ, CC_C, CC_NC) and state encodings. The existing decoder uses the same constants.
- One sub-module, `br_cond`: combinational. Inputs are `ir`, `zero_flag` and `carry_flag`; output `take` is 1 for jump, or for a conditional jump whose condition is met.

## Test plan
- Reset, then memory = {0x00, 0x05, 0x40, 0x07} with zero-wait ack:
  - `decode` at cycle 3 with `ir`=0x00, `operand`=0x05.
  - Second `ir`=0x40, `operand`=0x07; `pc`=4 after the second EXECUTE.
- Jump: 0x80, 0x20 at address 0 → `pc`=0x20 in the cycle after EXECUTE; next `mem_addr`=0x20.
- Conditional jumps, operand 0x30:
  - 0x90 with `zero_flag`=1 → `pc`=0x30.
  - 0x90 with `zero_flag`=0 → `pc`=2.
  - 0x9C with `carry_flag`=0 → `pc`=0x30.
- Memory stalls of 3 cycles per fetch:
  - `mem_req` and `mem_addr` stay stable for 4 cycles each.
  - Total instruction period is 10 cycles.
- PC wrap: start with `pc`=0xFF → operand fetched from 0x00; `pc`=0x01 at DECODE.
- Reset mid-FETCH_ARG, with a stalled ack arriving in the reset cycle: all outputs 0, `ir` and `operand` not updated, and refetch starts at address 0.
- With `INS_SEQ_IO_WAIT_EN`: 0xA0 with `io_ack` late by 5 cycles → `execute` high for 6 cycles. Opcode 0x40 → `execute` high for 1 cycle.
